// File: rtl/iterative_multiplier.sv
// iterative_multiplier: shift-add multiplier that retires one multiplier bit per clock.
// A start in IDLE or DONE latches the operands. WIDTH RUN cycles follow, and then
// DONE presents the full 2*WIDTH-bit product for one cycle.
// Optional feature: define MULT_SIGNED_EN to honour is_signed. With it, the block
// multiplies the operand magnitudes and negates the product when the operand signs
// differ. Without it, is_signed is ignored and every operation is unsigned.
module iterative_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 is_signed,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;

    logic               accept;
    logic               last_step;
    logic [WIDTH-1:0]   a_load;
    logic [WIDTH-1:0]   b_load;
    logic [WIDTH:0]     step_sum;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] result;

    // A start is honoured only outside RUN; a start during RUN is dropped.
    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_step = (state == RUN) && (count == CNT_W'(1));

    assign busy = (state == RUN);
    assign done = (state == DONE);

`ifdef MULT_SIGNED_EN
    logic sign;

    // Two's-complement magnitude. The most negative value maps to 2**(WIDTH-1),
    // which still fits in WIDTH unsigned bits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? ((~v) + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    // Operands enter the datapath as magnitudes when a signed request is made.
    always_comb begin
        a_load = is_signed ? magnitude(multiplicand) : multiplicand;
        b_load = is_signed ? magnitude(multiplier)   : multiplier;
    end

    // The final accumulator value is negated when the recorded sign is negative.
    always_comb begin
        result = sign ? ((~acc_next) + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_next;
    end

    // The sign is captured with the operands so a later is_signed change cannot affect it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign <= 1'b0;
        end else if (accept) begin
            sign <= is_signed && (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
        end
    end
`else
    logic unused_is_signed;
    assign unused_is_signed = is_signed;

    // Unsigned-only build: operands load as they are and the product needs no fix-up.
    always_comb begin
        a_load = multiplicand;
        b_load = multiplier;
        result = acc_next;
    end
`endif

    // One shift-add step. The optional add lands on the upper half, and its carry
    // becomes the new MSB after the right shift.
    always_comb begin
        step_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
        acc_next = {step_sum, acc[WIDTH-1:1]};
    end

    // Control FSM. RUN lasts exactly WIDTH cycles whatever the operand values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= RUN;
                        count <= CNT_W'(WIDTH);
                    end
                end
                RUN: begin
                    count <= count - CNT_W'(1);
                    if (last_step) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (accept) begin
                        state <= RUN;
                        count <= CNT_W'(WIDTH);
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    // Operand and accumulator datapath. The multiplier shifts right so its LSB
    // always selects the current partial product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (accept) begin
            mcand  <= a_load;
            mplier <= b_load;
            acc    <= '0;
        end else if (state == RUN) begin
            mplier <= mplier >> 1;
            acc    <= acc_next;
        end
    end

    // The product register changes only on the final step. It therefore holds the
    // previous result through RUN and never shows intermediate sums.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product <= '0;
        end else if (last_step) begin
            product <= result;
        end
    end

endmodule

// File: tb/tb_iterative_multiplier.sv
// tb_iterative_multiplier: table-driven vectors plus hand-written sequences for
// start-ignore, back-to-back and mid-RUN reset. Each accepted start pushes its
// expected product and done cycle onto a scoreboard queue. A monitor pops that
// entry when done appears.
module tb_iterative_multiplier;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   multiplicand = '0;
    logic [W-1:0]   multiplier = '0;
    logic           is_signed = 1'b0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [2*W-1:0] p;
        int             cyc;
    } exp_t;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           s;
        logic [2*W-1:0] p;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[10];

    iterative_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .is_signed    (is_signed),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every done must match the oldest expectation in both value and cycle.
    always @(negedge clk) begin
        if (rst_n && done) begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done cyc=%0d product=%h", cyc, product);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                checks++;
                if (product !== e.p) begin
                    failures++;
                    $display("FAIL product got=%h expected=%h", product, e.p);
                end
                checks++;
                if (cyc != e.cyc) begin
                    failures++;
                    $display("FAIL done_latency got_cyc=%0d expected_cyc=%0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    // Drives start for one cycle. When push is set, the expected result is queued.
    // The task returns at the first negedge after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic push, input logic [2*W-1:0] p);
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        is_signed    = s;
        start        = 1'b1;
        if (push) sbq.push_back('{p: p, cyc: cyc + 1 + W});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d expected=0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        int bcount;
        int dcount;
        bit seen;

        vecs[0] = '{8'h03, 8'h05, 1'b0, 16'h000F};
        vecs[1] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vecs[2] = '{8'h00, 8'hAB, 1'b0, 16'h0000};
        vecs[3] = '{8'hAB, 8'h00, 1'b0, 16'h0000};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 16'h4000};
        vecs[5] = '{8'hFF, 8'h01, 1'b0, 16'h00FF};
        vecs[6] = '{8'h12, 8'h34, 1'b0, 16'h03A8};
        vecs[7] = '{8'h01, 8'h01, 1'b0, 16'h0001};
        vecs[8] = '{8'h05, 8'hFD, 1'b0, 16'h04F1};
`ifdef MULT_SIGNED_EN
        vecs[9] = '{8'hFD, 8'h05, 1'b1, 16'hFFF1};
`else
        vecs[9] = '{8'hFD, 8'h05, 1'b1, 16'h04F1};
`endif

        // Asynchronous reset state, checked before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_product", 32'(product), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Busy is high for exactly W cycles after acceptance, then done follows.
        issue(8'h03, 8'h05, 1'b0, 1'b1, 16'h000F);
        bcount = 0;
        for (int j = 1; j <= 10; j++) begin
            if (j > 1) @(negedge clk);
            bcount += int'(busy);
            if (j == 8) check("done_early_j8", 32'(done), 32'h0);
        end
        check("busy_cycles", 32'(bcount), 32'd8);
        wait_drain();

        // Table vectors.
        for (int k = 0; k < 10; k++) begin
            issue(vecs[k].a, vecs[k].b, vecs[k].s, 1'b1, vecs[k].p);
            wait_drain();
        end

        // A start during RUN is ignored; a start in DONE runs back-to-back.
        issue(8'h07, 8'h06, 1'b0, 1'b1, 16'h002A);
        @(negedge clk);
        @(negedge clk);
        multiplicand = 8'h02;
        multiplier   = 8'h02;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_ignored_start", 32'(busy), 32'h1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_seen_7x6", 32'(seen), 32'h1);
        multiplicand = 8'h02;
        multiplier   = 8'h02;
        start        = 1'b1;
        sbq.push_back('{p: 16'h0004, cyc: cyc + 1 + W});
        @(negedge clk);
        start = 1'b0;
        check("busy_back_to_back", 32'(busy), 32'h1);
        wait_drain();

        // Reset in the middle of RUN aborts the operation with no done pulse.
        issue(8'h03, 8'h05, 1'b0, 1'b0, 16'h0000);
        repeat (3) @(negedge clk);
        check("busy_before_reset", 32'(busy), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("midrun_reset_busy", 32'(busy), 32'h0);
        check("midrun_reset_done", 32'(done), 32'h0);
        check("midrun_reset_product", 32'(product), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            dcount += int'(done);
        end
        check("no_done_after_abort", 32'(dcount), 32'h0);
        issue(8'h03, 8'h05, 1'b0, 1'b1, 16'h000F);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iterative_multiplier.md
ITERATIVE_MULTIPLIER -- requirements
Module: iterative_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..64).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a multiplication.
REQ-005 The block SHALL have port multiplicand, input, WIDTH bits: operand A.
REQ-006 The block SHALL have port multiplier, input, WIDTH bits: operand B.
REQ-007 The block SHALL have port is_signed, input, 1 bit: treat operands as two's complement (see Configuration).
REQ-008 The block SHALL have port busy, output, 1 bit: a multiplication is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: product valid, single-cycle pulse.
REQ-010 The block SHALL have port product, output, 2*WIDTH bits: result.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-012 A start sampled high in IDLE or DONE SHALL be accepted: on that edge, latch operands, load counter = WIDTH, clear accumulator, and enter RUN.
REQ-013 start SHALL be ignored while in RUN; latched operands and result SHALL be unaffected.
REQ-014 Each RUN edge SHALL perform one shift-add step: if the current multiplier LSB = 1, add the multiplicand to the upper WIDTH accumulator bits, keeping the carry-out as bit 2*WIDTH; shift the (2*WIDTH+1)-bit sum right by 1; decrement the counter.
REQ-015 After the WIDTH-th RUN step, the FSM SHALL enter DONE; DONE SHALL last exactly one cycle and then return to IDLE unless start is accepted.
REQ-016 Latency: done SHALL be high exactly WIDTH cycles after the accepting edge, independent of operand values (including zero operands).
REQ-017 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-018 product SHALL be the full unsigned 2*WIDTH-bit product with no truncation, and SHALL hold from DONE until the next accepting edge.
REQ-019 product SHALL be undefined-free (held at its previous value) while in RUN; intermediate accumulator values SHALL NOT appear on product.
REQ-020 Back-to-back operation: a start accepted in DONE SHALL give done again exactly WIDTH cycles later, with no idle cycle inserted.

Reset
REQ-021 rst_n low SHALL immediately, without waiting for clk, force IDLE, busy = 0, done = 0, product = 0, counter = 0 and accumulator = 0.
REQ-022 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first accepted start after release SHALL behave as from power-up.

Configuration
REQ-023 With macro MULT_SIGNED_EN defined and is_signed = 1 at acceptance, the block SHALL multiply the operand magnitudes, record sign = MSB(A) XOR MSB(B), and present the two's-complement-negated product in DONE when sign = 1; latency SHALL be unchanged.
REQ-024 With MULT_SIGNED_EN undefined, is_signed SHALL be ignored, all operations SHALL be unsigned, and no sign logic SHALL be synthesized.

Verification
REQ-025 The bench SHALL check, with WIDTH=8, A=3, B=5, start for one cycle -> busy for 8 cycles, one-cycle done pulse 8 cycles after acceptance, product=0x000F.
REQ-026 The bench SHALL check A=0xFF, B=0xFF -> product=0xFE01 (carry path exercised).
REQ-027 The bench SHALL check A=0x00, B=0xAB -> product=0x0000, done still exactly 8 cycles after acceptance.
REQ-028 The bench SHALL check A=7, B=6 accepted, then start with A=2, B=2 at cycle 3 -> ignored, product=0x002A; a start in the DONE cycle with A=2, B=2 -> product=0x0004 8 cycles later.
REQ-029 The bench SHALL check rst_n pulsed low at RUN cycle 4 -> busy, done and product = 0 immediately, no done pulse; a new start with A=3, B=5 -> 0x000F.
REQ-030 The bench SHALL check A=0xFD, B=0x05, is_signed=1 -> product=0xFFF1 with MULT_SIGNED_EN defined, 0x04F1 without it.
